pwr_phase_sequencer: RTL and testbench



---
 rtl/pwr_phase_sequencer_pkg.sv | 23 ++
 rtl/pwr_phase_sequencer_if.sv | 31 +++
 rtl/pwr_phase_sequencer_timer.sv | 35 +++
 rtl/pwr_phase_sequencer.sv | 151 +++++++++++++++
 tb/tb_pwr_phase_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pwr_phase_sequencer_pkg.sv
// Shared types and default sizing for the phase sequencer: FSM states,
// per-phase configuration record and the divider clamp limit.
package pwr_seq_pkg;

    localparam int NUM_PHASES = 4;
    localparam int PH_W       = 2;
    localparam int DIV_W      = 5;
    localparam int MAX_DIV    = 26;
    localparam int EDGE_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [DIV_W-1:0]  div_bit;
        logic [EDGE_W-1:0] edges;
    } phase_cfg_t;

endpackage

// File: rtl/pwr_phase_sequencer_if.sv
// Configuration/control inputs and status outputs of the phase sequencer.
interface pwr_phase_sequencer_if #(
    parameter int PH_W   = pwr_seq_pkg::PH_W,
    parameter int DIV_W  = pwr_seq_pkg::DIV_W,
    parameter int EDGE_W = pwr_seq_pkg::EDGE_W
);
    logic              cfg_we;
    logic [PH_W-1:0]   cfg_idx;
    logic [DIV_W-1:0]  cfg_div_bit;
    logic [EDGE_W-1:0] cfg_edges;
    logic [PH_W-1:0]   last_phase;
    logic              start;
    logic              abort;
    logic              alive;
    logic              blink_out;
    logic              edge_pulse;
    logic [PH_W-1:0]   phase_idx;
    logic              busy;
    logic              done;

    modport master (
        output cfg_we, cfg_idx, cfg_div_bit, cfg_edges, last_phase, start, abort,
        input  alive, blink_out, edge_pulse, phase_idx, busy, done
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_div_bit, cfg_edges, last_phase, start, abort,
        output alive, blink_out, edge_pulse, phase_idx, busy, done
    );

endinterface

// File: rtl/pwr_phase_sequencer_timer.sv
// Loadable down-counter; tc_o flags the zero count while enabled, and the
// counter reloads itself on that cycle so toggles stay exactly evenly spaced.
module pwr_rate_timer #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? load_val_i : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwr_phase_sequencer.sv
// Programmable activity sequencer: walks phase slots, toggling blink_out at a
// per-phase power-of-two rate for a per-phase number of edges.
module pwr_phase_sequencer #(
    parameter int NUM_PHASES = pwr_seq_pkg::NUM_PHASES,
    parameter int PH_W       = pwr_seq_pkg::PH_W,
    parameter int MAX_DIV    = pwr_seq_pkg::MAX_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pwr_phase_sequencer_if.slave  bus
);
    import pwr_seq_pkg::*;

    seq_state_e        state_q, state_d;
    phase_cfg_t        slot_q [NUM_PHASES];
    phase_cfg_t        cur_cfg;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [PH_W-1:0]   last_q, last_d;
    logic [EDGE_W-1:0] edges_left_q, edges_left_d;
    logic              blink_q, blink_d;
    logic              edge_q, edge_d;
    logic              done_q, done_d;
    logic              busy_q, alive_q;
    logic              tmr_load, tmr_en, tmr_tc;
    logic [MAX_DIV-1:0] reload_val;

    // Counter reload for a half-period of 2^min(d, MAX_DIV) cycles.
    function automatic logic [MAX_DIV-1:0] half_period_m1(input logic [DIV_W-1:0] d);
        int dc;
        dc = (int'(d) > MAX_DIV) ? MAX_DIV : int'(d);
        return {MAX_DIV{1'b1}} >> (MAX_DIV - dc);
    endfunction

    assign cur_cfg    = slot_q[phase_q];
    assign reload_val = half_period_m1(cur_cfg.div_bit);

    pwr_rate_timer #(.W(MAX_DIV)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .en_i       (tmr_en),
        .load_val_i (reload_val),
        .tc_o       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHASES; i++) slot_q[i] <= '0;
        end else if (bus.cfg_we && state_q == ST_IDLE) begin
            slot_q[bus.cfg_idx] <= '{div_bit: bus.cfg_div_bit, edges: bus.cfg_edges};
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        last_d       = last_q;
        edges_left_d = edges_left_q;
        blink_d      = blink_q;
        edge_d       = 1'b0;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    last_d  = bus.last_phase;
                    phase_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tmr_load     = 1'b1;
                edges_left_d = cur_cfg.edges;
                if (cur_cfg.edges == '0) begin
                    if (phase_q == last_q) state_d = ST_DONE;
                    else                   phase_d = phase_q + 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    blink_d      = ~blink_q;
                    edge_d       = 1'b1;
                    edges_left_d = edges_left_q - 1'b1;
                    if (edges_left_q == EDGE_W'(1)) begin
                        if (phase_q == last_q) begin
                            state_d = ST_DONE;
                        end else begin
                            phase_d = phase_q + 1'b1;
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                blink_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort cancels the run outright; phase_idx keeps its last value.
        if (state_q != ST_IDLE && bus.abort) begin
            state_d      = ST_IDLE;
            phase_d      = phase_q;
            edges_left_d = edges_left_q;
            blink_d      = 1'b0;
            edge_d       = 1'b0;
            done_d       = 1'b0;
            tmr_load     = 1'b0;
            tmr_en       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            last_q       <= '0;
            edges_left_q <= '0;
            blink_q      <= 1'b0;
            edge_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            alive_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            last_q       <= last_d;
            edges_left_q <= edges_left_d;
            blink_q      <= blink_d;
            edge_q       <= edge_d;
            done_q       <= done_d;
            busy_q       <= (state_d != ST_IDLE);
            alive_q      <= 1'b1;
        end
    end

    assign bus.alive      = alive_q;
    assign bus.blink_out  = blink_q;
    assign bus.edge_pulse = edge_q;
    assign bus.phase_idx  = phase_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_pwr_phase_sequencer.sv
// Scoreboard bench: stimulus predicts edge/done timestamps from the phase
// rules, a negedge monitor pops and compares whenever the DUT pulses.
module tb_pwr_phase_sequencer;

    localparam int MAXD = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    pwr_phase_sequencer_if #(.PH_W(2), .DIV_W(5), .EDGE_W(16)) bus();

    pwr_phase_sequencer #(.NUM_PHASES(4), .PH_W(2), .MAX_DIV(MAXD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_edge_t[$];
    bit exp_edge_v[$];
    int exp_edge_ph[$];
    int exp_done_t[$];
    int exp_done_ph[$];
    int mdl_div[4];
    int mdl_edges[4];
    bit in_run = 1'b0;

    int mon_t, mon_ph;
    bit mon_v;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int eff_div(input int d);
        return (d > MAXD) ? MAXD : d;
    endfunction

    // Timeline of one run accepted at edge a: each phase costs one LOAD cycle,
    // then every edge lands 2^d cycles after the previous point.
    task automatic model_run(input int a, input int last, output int done_t);
        int t;
        bit b;
        t = a;
        b = 1'b0;
        for (int p = 0; p <= last; p++) begin
            t += 1;
            for (int k = 0; k < mdl_edges[p]; k++) begin
                t += (1 << eff_div(mdl_div[p]));
                b = ~b;
                exp_edge_t.push_back(t);
                exp_edge_v.push_back(b);
                exp_edge_ph.push_back((k == mdl_edges[p] - 1 && p != last) ? p + 1 : p);
            end
        end
        done_t = t + 1;
        exp_done_t.push_back(done_t);
        exp_done_ph.push_back(last);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.edge_pulse) begin
                if (exp_edge_t.size() == 0) begin
                    check("edge_unexpected", cyc, -1);
                end else begin
                    mon_t  = exp_edge_t.pop_front();
                    mon_v  = exp_edge_v.pop_front();
                    mon_ph = exp_edge_ph.pop_front();
                    check("edge_time", cyc, mon_t);
                    check("edge_blink", bus.blink_out, mon_v);
                    check("edge_phase", bus.phase_idx, mon_ph);
                end
            end
            if (bus.done) begin
                if (exp_done_t.size() == 0) begin
                    check("done_unexpected", cyc, -1);
                end else begin
                    mon_t  = exp_done_t.pop_front();
                    mon_ph = exp_done_ph.pop_front();
                    check("done_time", cyc, mon_t);
                    check("done_blink", bus.blink_out, 0);
                    check("done_phase", bus.phase_idx, mon_ph);
                    check("done_busy", bus.busy, 0);
                end
            end
        end
    end

    task automatic cfg_write(input int idx, input int d, input int e);
        bus.cfg_we      = 1'b1;
        bus.cfg_idx     = idx[1:0];
        bus.cfg_div_bit = d[4:0];
        bus.cfg_edges   = e[15:0];
        @(negedge clk);
        bus.cfg_we = 1'b0;
        if (!in_run) begin
            mdl_div[idx]   = d;
            mdl_edges[idx] = e;
        end
    endtask

    task automatic launch(input int last, output int done_t);
        bus.last_phase = last[1:0];
        bus.start      = 1'b1;
        model_run(cyc + 1, last, done_t);
        in_run = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int done_t);
        int guard = 0;
        while (cyc <= done_t && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("run_finished", (cyc > done_t), 1);
        check("busy_idle", bus.busy, 0);
        check("edges_drained", exp_edge_t.size(), 0);
        check("done_drained", exp_done_t.size(), 0);
        in_run = 1'b0;
    endtask

    // Abort sampled at edge x: everything predicted from x onward is cancelled.
    task automatic abort_at(input int x);
        while (cyc < x - 1) @(negedge clk);
        while (exp_edge_t.size() != 0 && exp_edge_t[$] >= x) begin
            void'(exp_edge_t.pop_back());
            void'(exp_edge_v.pop_back());
            void'(exp_edge_ph.pop_back());
        end
        exp_done_t.delete();
        exp_done_ph.delete();
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_blink", bus.blink_out, 0);
        check("abort_edge", bus.edge_pulse, 0);
        in_run = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int dt, d1, d2, blinks, last;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_div_bit = '0; bus.cfg_edges = '0;
        bus.last_phase = '0; bus.start = 1'b0; bus.abort = 1'b0;
        for (int i = 0; i < 4; i++) begin mdl_div[i] = 0; mdl_edges[i] = 0; end

        repeat (100) @(negedge clk);
        check("rst_alive", bus.alive, 0);
        check("rst_blink", bus.blink_out, 0);
        check("rst_edge", bus.edge_pulse, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_phase", bus.phase_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("alive_after_rst", bus.alive, 1);
        check("busy_after_rst", bus.busy, 0);
        blinks = 0;
        repeat (200) begin @(negedge clk); if (bus.blink_out) blinks++; end
        check("idle_quiet", blinks, 0);

        cfg_write(0, 3, 4);
        launch(0, dt); wait_idle(dt);

        cfg_write(0, 3, 2); cfg_write(1, 1, 3);
        launch(1, dt); wait_idle(dt);

        cfg_write(0, 2, 1); cfg_write(1, 5, 0); cfg_write(2, 2, 1);
        launch(2, dt); wait_idle(dt);

        cfg_write(0, 4, 8);
        launch(0, dt);
        abort_at(cyc + 6);
        repeat (20) @(negedge clk);
        check("abort_stays_idle", bus.busy, 0);
        launch(0, dt); wait_idle(dt);

        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_abort_idle", bus.busy, 0);
        @(negedge clk);
        check("start_abort_idle2", bus.busy, 0);

        cfg_write(0, 2, 3);
        launch(0, dt);
        repeat (3) @(negedge clk);
        cfg_write(0, 5, 9);
        wait_idle(dt);
        launch(0, dt); wait_idle(dt);

        cfg_write(0, 31, 3); cfg_write(1, 7, 2);
        launch(1, dt); wait_idle(dt);

        cfg_write(0, 1, 2);
        bus.last_phase = 2'd0;
        bus.start = 1'b1;
        model_run(cyc + 1, 0, d1);
        model_run(d1 + 1, 0, d2);
        in_run = 1'b1;
        while (cyc < d1 + 1) @(negedge clk);
        bus.start = 1'b0;
        wait_idle(d2);

        repeat (6) begin
            for (int p = 0; p < 4; p++) cfg_write(p, $urandom_range(0, 7), $urandom_range(0, 5));
            last = $urandom_range(0, 3);
            launch(last, dt); wait_idle(dt);
        end

        cfg_write(0, 3, 6);
        launch(0, dt);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_blink", bus.blink_out, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_alive", bus.alive, 0);
        check("async_rst_phase", bus.phase_idx, 0);
        exp_edge_t.delete(); exp_edge_v.delete(); exp_edge_ph.delete();
        exp_done_t.delete(); exp_done_ph.delete();
        for (int i = 0; i < 4; i++) begin mdl_div[i] = 0; mdl_edges[i] = 0; end
        in_run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(3, dt); wait_idle(dt);
        launch(0, dt); wait_idle(dt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
